ibtb_tagged: RTL and testbench

IBTB_TAGGED -- requirements
Module: ibtb_tagged

---
 rtl/ibtb_tagged.sv | 181 ++++++++++++++++++
 tb/tb_ibtb_tagged.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ibtb_tagged.sv
// ibtb_tagged: set-associative, tagged indirect branch target buffer.
//
// Lookup: index = pc[IDX-1:0] ^ gh ^ asid, tag = pc[IDX+TAG_WIDTH-1:IDX] ^ asid.
// Results are registered and appear one cycle after read_valid. A read and an
// update in the same cycle see pre-update contents. Misses allocate the lowest
// invalid way, else the per-set round-robin victim.
//
// Optional feature macro: IBTB_TAGGED_CONFIDENCE_EN
//   defined   -> 2-bit confidence per entry gates target replacement on hits
//   undefined -> hit updates always overwrite the target
//
// Ports:
//   CLK, nRST                       clock, synchronous active-low reset
//   read_valid                      lookup request
//   read_src_pc38/ibtb_gh/asid      lookup key
//   read_resp_valid/hit/tgt_pc38    registered lookup result (target 0 on miss)
//   update_valid                    training request
//   update_src_pc38/ibtb_gh/asid    training key
//   update_tgt_pc38                 resolved target

package corep;
  typedef logic [37:0] pc38_t;
  typedef logic [7:0]  ibtb_gh_t;
  typedef logic [7:0]  asid_t;
endpackage

module ibtb_tagged #(
  parameter int unsigned IBTB_SETS = 64,
  parameter int unsigned IBTB_WAYS = 2,
  parameter int unsigned TAG_WIDTH = 8
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            read_valid,
  input  corep::pc38_t    read_src_pc38,
  input  corep::ibtb_gh_t read_ibtb_gh,
  input  corep::asid_t    read_asid,
  output logic            read_resp_valid,
  output logic            read_hit,
  output corep::pc38_t    read_tgt_pc38,
  input  logic            update_valid,
  input  corep::pc38_t    update_src_pc38,
  input  corep::ibtb_gh_t update_ibtb_gh,
  input  corep::asid_t    update_asid,
  input  corep::pc38_t    update_tgt_pc38
);

  localparam int unsigned IDX = $clog2(IBTB_SETS);
  localparam int unsigned WW  = (IBTB_WAYS > 1) ? $clog2(IBTB_WAYS) : 1;

  logic [IBTB_WAYS-1:0] valid_q [IBTB_SETS];
  logic [TAG_WIDTH-1:0] tag_q   [IBTB_SETS][IBTB_WAYS];
  corep::pc38_t         tgt_q   [IBTB_SETS][IBTB_WAYS];

  logic [IDX-1:0]       rd_idx, up_idx;
  logic [TAG_WIDTH-1:0] rd_tag, up_tag;
  logic                 rd_hit, up_hit, free_found, up_evict, wr_tgt;
  logic [WW-1:0]        rd_way, up_hit_way, free_way, wr_way, victim_cur;

  // Size casts zero-extend or truncate gh/asid to the field width.
  assign rd_idx = read_src_pc38[IDX-1:0] ^ IDX'(read_ibtb_gh) ^ IDX'(read_asid);
  assign up_idx = update_src_pc38[IDX-1:0] ^ IDX'(update_ibtb_gh) ^ IDX'(update_asid);
  assign rd_tag = read_src_pc38[IDX+TAG_WIDTH-1:IDX] ^ TAG_WIDTH'(read_asid);
  assign up_tag = update_src_pc38[IDX+TAG_WIDTH-1:IDX] ^ TAG_WIDTH'(update_asid);

  // Upper key bits outside the hash fields are intentionally ignored.
  logic unused_key_bits;
  assign unused_key_bits = ^{read_src_pc38, update_src_pc38, read_ibtb_gh,
                             update_ibtb_gh, read_asid, update_asid};

  // Lowest-numbered matching way wins.
  always_comb begin
    rd_hit = 1'b0;
    rd_way = '0;
    for (int unsigned w = 0; w < IBTB_WAYS; w++) begin
      if (!rd_hit && valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
        rd_hit = 1'b1;
        rd_way = WW'(w);
      end
    end
  end

  always_comb begin
    up_hit     = 1'b0;
    up_hit_way = '0;
    free_found = 1'b0;
    free_way   = '0;
    for (int unsigned w = 0; w < IBTB_WAYS; w++) begin
      if (!up_hit && valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
        up_hit     = 1'b1;
        up_hit_way = WW'(w);
      end
      if (!free_found && !valid_q[up_idx][w]) begin
        free_found = 1'b1;
        free_way   = WW'(w);
      end
    end
  end

  assign up_evict = !up_hit && !free_found;
  assign wr_way   = up_hit ? up_hit_way : (free_found ? free_way : victim_cur);

  // Victim pointer exists only when there is a choice of way; it advances
  // only when a valid entry is displaced and wraps by width truncation.
  if (IBTB_WAYS > 1) begin : g_victim
    logic [WW-1:0] victim_q [IBTB_SETS];
    assign victim_cur = victim_q[up_idx];
    always_ff @(posedge CLK) begin
      if (!nRST) begin
        for (int unsigned s = 0; s < IBTB_SETS; s++) victim_q[s] <= '0;
      end else if (update_valid && up_evict) begin
        victim_q[up_idx] <= victim_q[up_idx] + WW'(1);
      end
    end
  end else begin : g_no_victim
    assign victim_cur = '0;
  end

`ifdef IBTB_TAGGED_CONFIDENCE_EN
  logic [1:0] conf_q [IBTB_SETS][IBTB_WAYS];
  logic [1:0] conf_cur, conf_next;

  assign conf_cur = conf_q[up_idx][up_hit_way];

  // Misses and exhausted-confidence disagreements install the new target at 1.
  always_comb begin
    conf_next = 2'd1;
    wr_tgt    = 1'b1;
    if (up_hit) begin
      if (tgt_q[up_idx][up_hit_way] == update_tgt_pc38) begin
        wr_tgt    = 1'b0;
        conf_next = (conf_cur == 2'd3) ? 2'd3 : conf_cur + 2'd1;
      end else if (conf_cur != 2'd0) begin
        wr_tgt    = 1'b0;
        conf_next = conf_cur - 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < IBTB_SETS; s++)
        for (int unsigned w = 0; w < IBTB_WAYS; w++)
          conf_q[s][w] <= '0;
    end else if (update_valid) begin
      conf_q[up_idx][wr_way] <= conf_next;
    end
  end
`else
  assign wr_tgt = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned s = 0; s < IBTB_SETS; s++) valid_q[s] <= '0;
    end else if (update_valid) begin
      valid_q[up_idx][wr_way] <= 1'b1;
    end
  end

  // Tag/target storage carries no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (nRST && update_valid) begin
      tag_q[up_idx][wr_way] <= up_tag;
      if (wr_tgt) tgt_q[up_idx][wr_way] <= update_tgt_pc38;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      read_resp_valid <= 1'b0;
      read_hit        <= 1'b0;
      read_tgt_pc38   <= '0;
    end else begin
      read_resp_valid <= read_valid;
      read_hit        <= read_valid && rd_hit;
      read_tgt_pc38   <= (read_valid && rd_hit) ? tgt_q[rd_idx][rd_way] : '0;
    end
  end

endmodule

// File: tb/tb_ibtb_tagged.sv
// Directed bench for ibtb_tagged with default parameters (64 sets, 2 ways, 8-bit tags).
module tb_ibtb_tagged;
  import corep::*;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            read_valid;
  pc38_t           read_src_pc38;
  ibtb_gh_t        read_ibtb_gh;
  asid_t           read_asid;
  logic            read_resp_valid;
  logic            read_hit;
  pc38_t           read_tgt_pc38;
  logic            update_valid;
  pc38_t           update_src_pc38;
  ibtb_gh_t        update_ibtb_gh;
  asid_t           update_asid;
  pc38_t           update_tgt_pc38;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  ibtb_tagged #(.IBTB_SETS(64), .IBTB_WAYS(2), .TAG_WIDTH(8)) dut (
    .CLK(CLK), .nRST(nRST),
    .read_valid(read_valid), .read_src_pc38(read_src_pc38),
    .read_ibtb_gh(read_ibtb_gh), .read_asid(read_asid),
    .read_resp_valid(read_resp_valid), .read_hit(read_hit),
    .read_tgt_pc38(read_tgt_pc38),
    .update_valid(update_valid), .update_src_pc38(update_src_pc38),
    .update_ibtb_gh(update_ibtb_gh), .update_asid(update_asid),
    .update_tgt_pc38(update_tgt_pc38)
  );

  always #5 CLK = ~CLK;

  // One clock of stimulus; outputs are stable #1 after the edge on return.
  task automatic drive(input logic rv, input pc38_t rpc, input ibtb_gh_t rgh, input asid_t ra,
                       input logic uv, input pc38_t upc, input ibtb_gh_t ugh, input asid_t ua,
                       input pc38_t utgt);
    read_valid = rv; read_src_pc38 = rpc; read_ibtb_gh = rgh; read_asid = ra;
    update_valid = uv; update_src_pc38 = upc; update_ibtb_gh = ugh; update_asid = ua;
    update_tgt_pc38 = utgt;
    @(posedge CLK);
    #1;
    read_valid = 1'b0;
    update_valid = 1'b0;
  endtask

  task automatic rd(input pc38_t pc);
    drive(1'b1, pc, '0, '0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic up(input pc38_t pc, input pc38_t tgt);
    drive(1'b0, '0, '0, '0, 1'b1, pc, '0, '0, tgt);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    // Requests presented during reset must be dropped.
    nRST = 1'b0;
    read_valid = 1'b1; read_src_pc38 = 38'h40; read_ibtb_gh = '0; read_asid = '0;
    update_valid = 1'b1; update_src_pc38 = 38'h40; update_ibtb_gh = '0; update_asid = '0;
    update_tgt_pc38 = 38'h999;
    @(posedge CLK);
    #1;
    nRST = 1'b1; read_valid = 1'b0; update_valid = 1'b0;
    n_checks++; if (read_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", read_resp_valid); end
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b expected 0", read_hit); end
    n_checks++; if (read_tgt_pc38 !== 38'h0) begin n_fail++; $display("FAIL rst_tgt: got %h expected 0", read_tgt_pc38); end
    rd(38'h40);
    n_checks++; if (read_resp_valid !== 1'b1) begin n_fail++; $display("FAIL first_read_valid: got %b expected 1", read_resp_valid); end
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL first_read_hit: got %b expected 0", read_hit); end
    n_checks++; if (read_tgt_pc38 !== 38'h0) begin n_fail++; $display("FAIL first_read_tgt: got %h expected 0", read_tgt_pc38); end
  endtask

  task automatic test_basic();
    do_reset();
    up(38'h40, 38'h1234);
    rd(38'h40);
    n_checks++; if (read_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %b expected 1", read_hit); end
    n_checks++; if (read_tgt_pc38 !== 38'h1234) begin n_fail++; $display("FAIL basic_tgt: got %h expected 1234", read_tgt_pc38); end
    // Idle cycle with a matching key still on the bus: outputs must be zero.
    read_src_pc38 = 38'h40;
    drive(1'b0, 38'h40, '0, '0, 1'b0, '0, '0, '0, '0);
    n_checks++; if ({read_resp_valid, read_hit} !== 2'b00 || read_tgt_pc38 !== 38'h0) begin
      n_fail++; $display("FAIL idle_outputs: got v=%b h=%b t=%h expected all 0", read_resp_valid, read_hit, read_tgt_pc38); end
  endtask

  task automatic test_hash();
    do_reset();
    // pc 0x41: idx 1, tag 1.
    up(38'h41, 38'h55);
    drive(1'b1, 38'h40, 8'h01, 8'h00, 1'b0, '0, '0, '0, '0); // idx 0^1=1, tag 1
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'h55) begin
      n_fail++; $display("FAIL hash_gh: got h=%b t=%h expected h=1 t=55", read_hit, read_tgt_pc38); end
    drive(1'b1, 38'h00, 8'h00, 8'h01, 1'b0, '0, '0, '0, '0); // idx 1, tag 0^1=1
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'h55) begin
      n_fail++; $display("FAIL hash_asid: got h=%b t=%h expected h=1 t=55", read_hit, read_tgt_pc38); end
    drive(1'b1, 38'h41, 8'h00, 8'h01, 1'b0, '0, '0, '0, '0); // idx 0 -> miss
    n_checks++; if (read_hit !== 1'b0 || read_tgt_pc38 !== 38'h0) begin
      n_fail++; $display("FAIL hash_asid_miss: got h=%b t=%h expected h=0 t=0", read_hit, read_tgt_pc38); end
    drive(1'b1, 38'h41, 8'h40, 8'h00, 1'b0, '0, '0, '0, '0); // gh bit 6 truncated away
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'h55) begin
      n_fail++; $display("FAIL hash_gh_trunc: got h=%b t=%h expected h=1 t=55", read_hit, read_tgt_pc38); end
  endtask

  task automatic test_eviction();
    do_reset();
    up(38'h000, 38'hA0);  // way 0
    up(38'h040, 38'hB0);  // way 1
    up(38'h080, 38'hC0);  // evicts way 0, victim -> 1
    rd(38'h000);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL evict_old_miss: got %b expected 0", read_hit); end
    rd(38'h040);
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'hB0) begin
      n_fail++; $display("FAIL evict_b_hit: got h=%b t=%h expected h=1 t=b0", read_hit, read_tgt_pc38); end
    rd(38'h080);
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'hC0) begin
      n_fail++; $display("FAIL evict_c_hit: got h=%b t=%h expected h=1 t=c0", read_hit, read_tgt_pc38); end
    up(38'h080, 38'hC0);  // hit update: victim stays at 1
    up(38'h0C0, 38'hD0);  // evicts way 1 (0x040), victim wraps -> 0
    rd(38'h040);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL victim_hold_miss: got %b expected 0", read_hit); end
    rd(38'h080);
    n_checks++; if (read_hit !== 1'b1) begin n_fail++; $display("FAIL victim_hold_hit: got %b expected 1", read_hit); end
    up(38'h100, 38'hE0);  // evicts way 0 (0x080)
    rd(38'h080);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL victim_wrap_miss: got %b expected 0", read_hit); end
    rd(38'h0C0);
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'hD0) begin
      n_fail++; $display("FAIL victim_wrap_hit: got h=%b t=%h expected h=1 t=d0", read_hit, read_tgt_pc38); end
  endtask

  task automatic test_back_to_back();
    pc38_t exp_next;
    do_reset();
    up(38'h40, 38'h10);
    drive(1'b1, 38'h40, '0, '0, 1'b1, 38'h40, '0, '0, 38'h20);
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'h10) begin
      n_fail++; $display("FAIL same_cycle_old: got h=%b t=%h expected h=1 t=10", read_hit, read_tgt_pc38); end
`ifdef IBTB_TAGGED_CONFIDENCE_EN
    exp_next = 38'h10;
`else
    exp_next = 38'h20;
`endif
    rd(38'h40);
    n_checks++; if (read_tgt_pc38 !== exp_next) begin
      n_fail++; $display("FAIL same_cycle_next: got %h expected %h", read_tgt_pc38, exp_next); end
  endtask

  task automatic test_confidence();
    do_reset();
`ifdef IBTB_TAGGED_CONFIDENCE_EN
    up(38'h40, 38'h10); up(38'h40, 38'h10); up(38'h40, 38'h10);  // conf 3
    up(38'h40, 38'h20); rd(38'h40);                                // conf 2
    n_checks++; if (read_tgt_pc38 !== 38'h10) begin n_fail++; $display("FAIL conf_3to2: got %h expected 10", read_tgt_pc38); end
    up(38'h40, 38'h20); rd(38'h40);                                // conf 1
    n_checks++; if (read_tgt_pc38 !== 38'h10) begin n_fail++; $display("FAIL conf_2to1: got %h expected 10", read_tgt_pc38); end
    up(38'h40, 38'h20); rd(38'h40);                                // conf 0
    n_checks++; if (read_tgt_pc38 !== 38'h10) begin n_fail++; $display("FAIL conf_1to0: got %h expected 10", read_tgt_pc38); end
    up(38'h40, 38'h20); rd(38'h40);                                // replace
    n_checks++; if (read_tgt_pc38 !== 38'h20) begin n_fail++; $display("FAIL conf_replace: got %h expected 20", read_tgt_pc38); end
`else
    up(38'h40, 38'h10); up(38'h40, 38'h10);
    up(38'h40, 38'h20); rd(38'h40);
    n_checks++; if (read_tgt_pc38 !== 38'h20) begin n_fail++; $display("FAIL overwrite_1: got %h expected 20", read_tgt_pc38); end
    up(38'h40, 38'h30); rd(38'h40);
    n_checks++; if (read_tgt_pc38 !== 38'h30) begin n_fail++; $display("FAIL overwrite_2: got %h expected 30", read_tgt_pc38); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    up(38'h000, 38'h1); up(38'h040, 38'h2); up(38'h080, 38'h3); up(38'h001, 38'h4);
    do_reset();  // set 0 victim was 1 before this
    rd(38'h040);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miss_a: got %b expected 0", read_hit); end
    rd(38'h080);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_miss_b: got %b expected 0", read_hit); end
    rd(38'h001);
    n_checks++; if (read_hit !== 1'b0 || read_tgt_pc38 !== 38'h0) begin
      n_fail++; $display("FAIL rst_mid_miss_c: got h=%b t=%h expected h=0 t=0", read_hit, read_tgt_pc38); end
    up(38'h000, 38'h5); up(38'h040, 38'h6); up(38'h080, 38'h7);  // third evicts way 0
    rd(38'h000);
    n_checks++; if (read_hit !== 1'b0) begin n_fail++; $display("FAIL rst_mid_realloc_miss: got %b expected 0", read_hit); end
    rd(38'h040);
    n_checks++; if (read_hit !== 1'b1 || read_tgt_pc38 !== 38'h6) begin
      n_fail++; $display("FAIL rst_mid_realloc_hit: got h=%b t=%h expected h=1 t=6", read_hit, read_tgt_pc38); end
  endtask

  initial begin
    read_valid = 1'b0; read_src_pc38 = '0; read_ibtb_gh = '0; read_asid = '0;
    update_valid = 1'b0; update_src_pc38 = '0; update_ibtb_gh = '0; update_asid = '0;
    update_tgt_pc38 = '0; nRST = 1'b0;
    test_reset();
    test_basic();
    test_hash();
    test_eviction();
    test_back_to_back();
    test_confidence();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
